cdb_arbiter: RTL and testbench

Parametrised completion/broadcast stage between the functional units and the common data bus. Accepts results from `NUM_SRC` FU result ports over a valid/ready handshake and buffers one result per source. Each cycle it grants up to `N_CDB` buffered results onto registered CDB lanes for the PRF, reservation stations and ROB. Supersedes the fixed-count FU→CDB coupling: source count, lane count and field widths are generic, back-pressure is explicit, and priority is selectable.

---
 rtl/cdb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - FU result holding registers and N-lane CDB arbiter; CDB_RR_PRIORITY_EN selects round-robin priority
module cdb_arbiter #(
  parameter int NUM_SRC = 6,
  parameter int N_CDB   = 2,
  parameter int PRN_W   = 6,
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 5,
  localparam int GC_W   = $clog2(N_CDB + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*PRN_W-1:0]   src_prn,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_SRC*ROB_W-1:0]   src_rob_idx,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [N_CDB-1:0]           cdb_valid,
  output logic [N_CDB*PRN_W-1:0]     cdb_prn,
  output logic [N_CDB*DATA_W-1:0]    cdb_data,
  output logic [N_CDB*ROB_W-1:0]     cdb_rob_idx,
  output logic [GC_W-1:0]            grant_count
);

`ifdef CDB_RR_PRIORITY_EN
  localparam int PTR_W = $clog2(NUM_SRC);
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  logic [NUM_SRC-1:0] hold_valid_q, hold_valid_d;
  logic [PRN_W-1:0]   hold_prn_q  [NUM_SRC];
  logic [PRN_W-1:0]   hold_prn_d  [NUM_SRC];
  logic [DATA_W-1:0]  hold_data_q [NUM_SRC];
  logic [DATA_W-1:0]  hold_data_d [NUM_SRC];
  logic [ROB_W-1:0]   hold_rob_q  [NUM_SRC];
  logic [ROB_W-1:0]   hold_rob_d  [NUM_SRC];

  logic [N_CDB-1:0]        lane_valid_q, lane_valid_d;
  logic [N_CDB*PRN_W-1:0]  lane_prn_q, lane_prn_d;
  logic [N_CDB*DATA_W-1:0] lane_data_q, lane_data_d;
  logic [N_CDB*ROB_W-1:0]  lane_rob_q, lane_rob_d;
  logic [GC_W-1:0]         grant_count_q, grant_count_d;

  logic [NUM_SRC-1:0] grant;
  int                 rank [NUM_SRC];
  int                 n_grant;
  int                 origin;

  // Scan holding entries from the origin (two passes: origin..end, then 0..origin-1), grant the first N_CDB valid ones
  always_comb begin
    grant   = '0;
    n_grant = 0;
    for (int i = 0; i < NUM_SRC; i++) rank[i] = 0;
`ifdef CDB_RR_PRIORITY_EN
    origin   = int'(rr_ptr_q);
    rr_ptr_d = rr_ptr_q;
`else
    origin   = 0;
`endif
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (((p == 0) == (i >= origin)) && hold_valid_q[i] && (n_grant < N_CDB)) begin
          grant[i] = 1'b1;
          rank[i]  = n_grant;
          n_grant  = n_grant + 1;
`ifdef CDB_RR_PRIORITY_EN
          rr_ptr_d = (i == NUM_SRC - 1) ? '0 : PTR_W'(i + 1);
`endif
        end
      end
    end
`ifdef CDB_RR_PRIORITY_EN
    if (squash) rr_ptr_d = rr_ptr_q;
`endif
  end

  // A slot is free when empty or being broadcast this cycle; squash blocks all accepts
  assign src_ready = squash ? '0 : (~hold_valid_q | grant);

  // Holding register update: squash clears, accept overwrites, grant without replacement clears
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_prn_d   = hold_prn_q;
    hold_data_d  = hold_data_q;
    hold_rob_d   = hold_rob_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (squash) begin
        hold_valid_d[i] = 1'b0;
      end else if (src_valid[i] && src_ready[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_prn_d[i]   = src_prn[i*PRN_W +: PRN_W];
        hold_data_d[i]  = src_data[i*DATA_W +: DATA_W];
        hold_rob_d[i]   = src_rob_idx[i*ROB_W +: ROB_W];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
  end

  // Route granted entries to lanes in scan order; unused lanes and squash cycles drive all-zero lanes
  always_comb begin
    lane_valid_d  = '0;
    lane_prn_d    = '0;
    lane_data_d   = '0;
    lane_rob_d    = '0;
    grant_count_d = '0;
    if (!squash) begin
      grant_count_d = GC_W'(n_grant);
      for (int j = 0; j < N_CDB; j++) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant[i] && (rank[i] == j)) begin
            lane_valid_d[j]                  = 1'b1;
            lane_prn_d[j*PRN_W +: PRN_W]     = hold_prn_q[i];
            lane_data_d[j*DATA_W +: DATA_W]  = hold_data_q[i];
            lane_rob_d[j*ROB_W +: ROB_W]     = hold_rob_q[i];
          end
        end
      end
    end
  end

  // State registers; reset discards buffered and lane contents immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid_q  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_prn_q[i]  <= '0;
        hold_data_q[i] <= '0;
        hold_rob_q[i]  <= '0;
      end
      lane_valid_q  <= '0;
      lane_prn_q    <= '0;
      lane_data_q   <= '0;
      lane_rob_q    <= '0;
      grant_count_q <= '0;
`ifdef CDB_RR_PRIORITY_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_prn_q    <= hold_prn_d;
      hold_data_q   <= hold_data_d;
      hold_rob_q    <= hold_rob_d;
      lane_valid_q  <= lane_valid_d;
      lane_prn_q    <= lane_prn_d;
      lane_data_q   <= lane_data_d;
      lane_rob_q    <= lane_rob_d;
      grant_count_q <= grant_count_d;
`ifdef CDB_RR_PRIORITY_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  assign cdb_valid   = lane_valid_q;
  assign cdb_prn     = lane_prn_q;
  assign cdb_data    = lane_data_q;
  assign cdb_rob_idx = lane_rob_q;
  assign grant_count = grant_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed self-checking bench for cdb_arbiter against a queue-based reference model
module tb_cdb_arbiter;
  localparam int NUM_SRC = 6;
  localparam int N_CDB   = 2;
  localparam int PRN_W   = 6;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 5;
  localparam int GC_W    = $clog2(N_CDB + 1);

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic                      squash = 1'b0;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC*PRN_W-1:0]  src_prn = '0;
  logic [NUM_SRC*DATA_W-1:0] src_data = '0;
  logic [NUM_SRC*ROB_W-1:0]  src_rob_idx = '0;
  logic [NUM_SRC-1:0]        src_ready;
  logic [N_CDB-1:0]          cdb_valid;
  logic [N_CDB*PRN_W-1:0]    cdb_prn;
  logic [N_CDB*DATA_W-1:0]   cdb_data;
  logic [N_CDB*ROB_W-1:0]    cdb_rob_idx;
  logic [GC_W-1:0]           grant_count;

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .N_CDB(N_CDB), .PRN_W(PRN_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .src_valid(src_valid), .src_prn(src_prn), .src_data(src_data), .src_rob_idx(src_rob_idx),
    .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_data(cdb_data),
    .cdb_rob_idx(cdb_rob_idx), .grant_count(grant_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered results per source, pending lane contents, priority origin
  bit                m_hv   [NUM_SRC];
  logic [PRN_W-1:0]  m_prn  [NUM_SRC];
  logic [DATA_W-1:0] m_data [NUM_SRC];
  logic [ROB_W-1:0]  m_rob  [NUM_SRC];
  bit                m_lv   [N_CDB];
  logic [PRN_W-1:0]  m_lprn [N_CDB];
  logic [DATA_W-1:0] m_ldata[N_CDB];
  logic [ROB_W-1:0]  m_lrob [N_CDB];
  int                m_gc;
  int                m_ptr;
  int                m_order[$];
  bit                m_g    [NUM_SRC];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      m_hv[i] = 0; m_prn[i] = '0; m_data[i] = '0; m_rob[i] = '0;
    end
    for (int j = 0; j < N_CDB; j++) begin
      m_lv[j] = 0; m_lprn[j] = '0; m_ldata[j] = '0; m_lrob[j] = '0;
    end
    m_gc = 0;
    m_ptr = 0;
  endfunction

  // Winners: walk sources in rotated order from the origin, keep the first N_CDB that hold a result
  function automatic void model_arb();
    int org;
`ifdef CDB_RR_PRIORITY_EN
    org = m_ptr;
`else
    org = 0;
`endif
    m_order.delete();
    for (int i = 0; i < NUM_SRC; i++) m_g[i] = 0;
    for (int d = 0; d < NUM_SRC; d++) begin
      int idx;
      idx = (org + d) % NUM_SRC;
      if (m_hv[idx] && m_order.size() < N_CDB) begin
        m_order.push_back(idx);
        m_g[idx] = 1;
      end
    end
  endfunction

  function automatic void model_adv();
    int n;
    n = m_order.size();
    for (int j = 0; j < N_CDB; j++) begin
      m_lv[j] = 0; m_lprn[j] = '0; m_ldata[j] = '0; m_lrob[j] = '0;
      if (!squash && j < n) begin
        m_lv[j]    = 1;
        m_lprn[j]  = m_prn[m_order[j]];
        m_ldata[j] = m_data[m_order[j]];
        m_lrob[j]  = m_rob[m_order[j]];
      end
    end
    m_gc = squash ? 0 : n;
    if (!squash && n > 0) m_ptr = (m_order[n-1] + 1) % NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      bit rdy;
      rdy = !squash && (!m_hv[i] || m_g[i]);
      if (squash) m_hv[i] = 0;
      else if (src_valid[i] && rdy) begin
        m_hv[i]   = 1;
        m_prn[i]  = src_prn[i*PRN_W +: PRN_W];
        m_data[i] = src_data[i*DATA_W +: DATA_W];
        m_rob[i]  = src_rob_idx[i*ROB_W +: ROB_W];
      end else if (m_g[i]) m_hv[i] = 0;
    end
  endfunction

  // One cycle: compare all outputs to the model mid-cycle, advance model, move to next falling edge
  task automatic tick(input string tag);
    logic [NUM_SRC-1:0]      er;
    logic [N_CDB-1:0]        ev;
    logic [N_CDB*PRN_W-1:0]  ep;
    logic [N_CDB*DATA_W-1:0] ed;
    logic [N_CDB*ROB_W-1:0]  eo;
    #1;
    model_arb();
    for (int i = 0; i < NUM_SRC; i++) er[i] = !squash && (!m_hv[i] || m_g[i]);
    for (int j = 0; j < N_CDB; j++) begin
      ev[j] = m_lv[j];
      ep[j*PRN_W +: PRN_W]    = m_lprn[j];
      ed[j*DATA_W +: DATA_W]  = m_ldata[j];
      eo[j*ROB_W +: ROB_W]    = m_lrob[j];
    end
    check_eq({tag, ".ready"}, src_ready, er);
    check_eq({tag, ".valid"}, cdb_valid, ev);
    check_eq({tag, ".gcnt"}, grant_count, m_gc);
    check_eq({tag, ".prn"}, cdb_prn, ep);
    check_eq({tag, ".data"}, cdb_data, ed);
    check_eq({tag, ".rob"}, cdb_rob_idx, eo);
    model_adv();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clr_src();
    src_valid = '0; src_prn = '0; src_data = '0; src_rob_idx = '0;
  endtask

  task automatic set_src(input int i, input logic [PRN_W-1:0] p, input logic [DATA_W-1:0] d, input logic [ROB_W-1:0] r);
    src_valid[i] = 1'b1;
    src_prn[i*PRN_W +: PRN_W]    = p;
    src_data[i*DATA_W +: DATA_W] = d;
    src_rob_idx[i*ROB_W +: ROB_W] = r;
  endtask

  task automatic drain();
    clr_src();
    squash = 1'b0;
    for (int k = 0; k < 5; k++) tick("drain");
  endtask

  function automatic bit lane_has_rob(input logic [ROB_W-1:0] r);
    bit hit;
    hit = 0;
    for (int j = 0; j < N_CDB; j++)
      if (cdb_valid[j] && cdb_rob_idx[j*ROB_W +: ROB_W] == r) hit = 1;
    return hit;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_at;
    bit hit;
    model_reset();
    #1;
    check_eq("rst.valid", cdb_valid, 0);
    check_eq("rst.gcnt", grant_count, 0);
    check_eq("rst.data", cdb_data, 0);
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    #1;
    check_eq("idle.ready", src_ready, 6'b111111);
    for (int k = 0; k < 10; k++) tick("idle");

    // All six present at once from pointer 0
    for (int i = 0; i < NUM_SRC; i++) set_src(i, PRN_W'(8 + i), 32'hA000_0000 + i, ROB_W'(16 + i));
    tick("os0");
    clr_src();
    #1 check_eq("os.rdy1", src_ready, 6'b000011);
    tick("os1");
    #1 check_eq("os.rdy2", src_ready, 6'b001111);
    check_eq("os.lane01", cdb_rob_idx, {5'd17, 5'd16});
    check_eq("os.gc01", grant_count, 2);
    tick("os2");
    #1 check_eq("os.rdy3", src_ready, 6'b111111);
    check_eq("os.lane23", cdb_rob_idx, {5'd19, 5'd18});
    tick("os3");
    #1 check_eq("os.lane45", cdb_prn, {6'd13, 6'd12});
    tick("os4");
    drain();

    // Single result from source 3
    set_src(3, 6'h15, 32'hDEADBEEF, 5'd7);
    tick("one0");
    clr_src();
    tick("one1");
    #1;
    check_eq("one.valid", cdb_valid, 2'b01);
    check_eq("one.prn", cdb_prn, {6'h00, 6'h15});
    check_eq("one.data", cdb_data, {32'h0, 32'hDEADBEEF});
    check_eq("one.rob", cdb_rob_idx, {5'd0, 5'd7});
    tick("one2");
    drain();

    // Fairness: sources 0 and 1 stream, source 5 presents once
    seen_at = 999;
    for (int k = 0; k < 16; k++) begin
      clr_src();
      if (k < 8) begin
        set_src(0, PRN_W'(k), 32'h0000_0100 + k, 5'd0);
        set_src(1, PRN_W'(k + 1), 32'h0000_0200 + k, 5'd1);
      end
      if (k == 0) set_src(5, 6'h3F, 32'h5555_5555, 5'd31);
      tick("fair");
      if (seen_at == 999 && lane_has_rob(5'd31)) seen_at = k + 1;
    end
`ifdef CDB_RR_PRIORITY_EN
    check_eq("fair.rr_bound", (seen_at <= 3), 1);
`else
    check_eq("fair.fixed_wait", (seen_at >= 9 && seen_at < 999), 1);
`endif
    drain();

    // Squash with lanes valid and four entries buffered
    for (int i = 0; i < NUM_SRC; i++) set_src(i, PRN_W'(32 + i), 32'hB000_0000 + i, ROB_W'(20 + i));
    tick("sq0");
    clr_src();
    tick("sq1");
    #1 check_eq("sq.pre_valid", cdb_valid, 2'b11);
    squash = 1'b1;
    set_src(2, 6'h2A, 32'hCAFE_F00D, 5'd30);
    tick("sq2");
    squash = 1'b0;
    clr_src();
    #1;
    check_eq("sq.valid", cdb_valid, 2'b00);
    check_eq("sq.empty", src_ready, 6'b111111);
    hit = 0;
    for (int k = 0; k < 5; k++) begin
      tick("sq_after");
      if (lane_has_rob(5'd30)) hit = 1;
    end
    check_eq("sq.src2_never", hit, 0);
    drain();

    // Asynchronous reset while lanes are valid
    for (int i = 0; i < NUM_SRC; i++) set_src(i, PRN_W'(40 + i), 32'hC000_0000 + i, ROB_W'(i));
    tick("ar0");
    clr_src();
    tick("ar1");
    #1 check_eq("ar.pre_valid", cdb_valid, 2'b11);
    #1 reset = 1'b0;
    #1;
    check_eq("ar.valid", cdb_valid, 2'b00);
    check_eq("ar.gcnt", grant_count, 0);
    model_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 6; k++) tick("ar_after");

    // Randomized traffic with occasional squash
    for (int k = 0; k < 400; k++) begin
      clr_src();
      for (int i = 0; i < NUM_SRC; i++)
        if ($urandom_range(0, 9) < 6)
          set_src(i, PRN_W'($urandom), DATA_W'($urandom), ROB_W'($urandom));
      squash = ($urandom_range(0, 19) == 0);
      tick("rnd");
    end
    squash = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
